// File: rtl/game_pkg.sv
// Shared definitions for the game controller: FSM state codes, BCD digit width,
// serve-indicator codes and the two-digit BCD helpers.
package game_pkg;

  localparam int DIG_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] BALL_NONE = 2'b00;
  localparam logic [1:0] BALL_P1   = 2'b01;
  localparam logic [1:0] BALL_P2   = 2'b10;

  function automatic logic [DIG_W-1:0] win_tens(input int w);
    return DIG_W'(w / 10);
  endfunction

  function automatic logic [DIG_W-1:0] win_ones(input int w);
    return DIG_W'(w % 10);
  endfunction

  // Two-digit BCD increment {tens, ones}; 99 wraps to 00.
  function automatic logic [2*DIG_W-1:0] bcd_inc(input logic [2*DIG_W-1:0] v);
    logic [DIG_W-1:0] o;
    logic [DIG_W-1:0] t;
    o = v[DIG_W-1:0];
    t = v[2*DIG_W-1:DIG_W];
    if (o >= DIG_W'(9)) begin
      o = '0;
      t = (t >= DIG_W'(9)) ? '0 : t + DIG_W'(1);
    end else begin
      o = o + DIG_W'(1);
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter with synchronous clear and increment (99 -> 00).
module bcd_counter2
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [DIG_W-1:0] ones,
  output logic [DIG_W-1:0] tens
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      {tens, ones} <= bcd_inc({tens, ones});
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-control FSM (IDLE/SERVE/PLAY/OVER) driving score digits and overlay selects.
// Win detection and the OVER screen are enabled by defining SCORE_LIMIT_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refr_tick,
  input  logic             btn_start,
  input  logic             pt_p1,
  input  logic             pt_p2,
  output logic [DIG_W-1:0] dig0,
  output logic [DIG_W-1:0] dig1,
  output logic [DIG_W-1:0] dig2,
  output logic [DIG_W-1:0] dig3,
  output logic [1:0]       ball,
  output logic             graph_still,
  output logic             show_rule,
  output logic             show_over,
  output logic             winner
);

`ifdef SCORE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [7:0]         SERVE_LD = 8'(SERVE_FRAMES);
  localparam logic [7:0]         OVER_LD  = 8'(OVER_FRAMES);
  localparam logic [2*DIG_W-1:0] WIN_CODE = {win_tens(WIN_SCORE), win_ones(WIN_SCORE)};

  logic [1:0] state, nxt_state;
  logic [7:0] timer, nxt_timer;
  logic [1:0] ball_nxt;
  logic       winner_nxt;
  logic       btn_prev, start_evt;
  logic       inc1, inc2, clr_sc;
  logic       win1, win2;

  assign start_evt = btn_start & ~btn_prev;
  assign win1 = LIMIT_EN && (bcd_inc({dig1, dig0}) == WIN_CODE);
  assign win2 = LIMIT_EN && (bcd_inc({dig3, dig2}) == WIN_CODE);

  bcd_counter2 u_score_p1 (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_sc),
    .inc  (inc1),
    .ones (dig0),
    .tens (dig1)
  );

  bcd_counter2 u_score_p2 (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_sc),
    .inc  (inc2),
    .ones (dig2),
    .tens (dig3)
  );

  always_comb begin
    nxt_state  = state;
    nxt_timer  = timer;
    ball_nxt   = ball;
    winner_nxt = winner;
    inc1       = 1'b0;
    inc2       = 1'b0;
    clr_sc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_evt) begin
          clr_sc    = 1'b1;
          ball_nxt  = BALL_P1;
          nxt_timer = SERVE_LD;
          nxt_state = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (timer == 8'd0) nxt_state = ST_PLAY;
        else if (refr_tick) nxt_timer = timer - 8'd1;
      end
      ST_PLAY: begin
        // P1 has priority on a simultaneous point; the P2 pulse is dropped.
        if (pt_p1) begin
          inc1 = 1'b1;
          if (win1) begin
            winner_nxt = 1'b0;
            ball_nxt   = BALL_NONE;
            nxt_timer  = OVER_LD;
            nxt_state  = ST_OVER;
          end else begin
            ball_nxt  = BALL_P2;
            nxt_timer = SERVE_LD;
            nxt_state = ST_SERVE;
          end
        end else if (pt_p2) begin
          inc2 = 1'b1;
          if (win2) begin
            winner_nxt = 1'b1;
            ball_nxt   = BALL_NONE;
            nxt_timer  = OVER_LD;
            nxt_state  = ST_OVER;
          end else begin
            ball_nxt  = BALL_P1;
            nxt_timer = SERVE_LD;
            nxt_state = ST_SERVE;
          end
        end
      end
      default: begin
        // OVER: start only counts once the hold-off timer has drained.
        ball_nxt = BALL_NONE;
        if (timer != 8'd0) begin
          if (refr_tick) nxt_timer = timer - 8'd1;
        end else if (start_evt) begin
          nxt_state = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= 8'd0;
      btn_prev    <= 1'b0;
      ball        <= BALL_NONE;
      winner      <= 1'b0;
      graph_still <= 1'b1;
      show_rule   <= 1'b1;
      show_over   <= 1'b0;
    end else begin
      state       <= nxt_state;
      timer       <= nxt_timer;
      btn_prev    <= btn_start;
      ball        <= ball_nxt;
      winner      <= winner_nxt;
      graph_still <= (nxt_state != ST_PLAY);
      show_rule   <= (nxt_state == ST_IDLE);
      show_over   <= (nxt_state == ST_OVER);
    end
  end

endmodule
